// File: rtl/dm_wb_dcache.sv
// dm_wb_dcache: direct-mapped write-back data cache with 64-byte lines.
// Line fills and victim writebacks use separate level-held handshakes.
// Optional build macro: DM_WB_DCACHE_STATS_EN adds hit/miss/writeback counters.

package CACHE;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } cache_cmd_t;
endpackage

module dm_wb_dcache #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  CACHE::cache_cmd_t   req_cmd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [63:0]         req_data,
  output logic                respcyc,
  output logic [63:0]         resp_data,
  output logic                rd_reqcyc,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_respcyc,
  input  logic [511:0]        rd_data,
  output logic                wt_reqcyc,
  output logic [ADDR_W-1:0]   wt_addr,
  output logic [511:0]        wt_data,
  input  logic                wt_respcyc
`ifdef DM_WB_DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         wb_cnt
`endif
);

  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned LADDR_W = ADDR_W - 6;
  localparam int unsigned TAG_W   = ADDR_W - 6 - IDX_W;
  localparam int unsigned LINE_W  = 512;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 flush_q, flush_d;
  logic [LADDR_W-1:0]   miss_line_q;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    line_q [NUM_LINES];

  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           req_word;
  logic [IDX_W-1:0]     miss_idx;
  logic [TAG_W-1:0]     miss_tag;
  logic                 match_c;

  // control strobes from the FSM to the storage arrays
  logic                 latch_miss_c;
  logic                 hit_wr_c;
  logic                 inv_req_c;
  logic                 wb_done_c;
  logic                 fill_en_c;
  logic                 hit_rw_c;
  logic                 miss_rw_c;

  // address split and tag lookup
  assign req_idx  = req_addr[6 +: IDX_W];
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_word = req_addr[5:3];
  assign miss_idx = miss_line_q[IDX_W-1:0];
  assign miss_tag = miss_line_q[LADDR_W-1 -: TAG_W];
  assign match_c  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // read data and bus payloads come straight from the arrays
  assign resp_data = line_q[req_idx][{req_word, 6'd0} +: 64];
  assign rd_addr   = {miss_line_q, 6'd0};
  assign wt_addr   = {tag_q[miss_idx], miss_idx, 6'd0};
  assign wt_data   = line_q[miss_idx];

  // FSM state and latched miss context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      flush_q     <= 1'b0;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (latch_miss_c) miss_line_q <= req_addr[ADDR_W-1:6];
    end
  end

  // next-state, handshake outputs and array update strobes
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    respcyc      = 1'b0;
    rd_reqcyc    = 1'b0;
    wt_reqcyc    = 1'b0;
    latch_miss_c = 1'b0;
    hit_wr_c     = 1'b0;
    inv_req_c    = 1'b0;
    wb_done_c    = 1'b0;
    fill_en_c    = 1'b0;
    hit_rw_c     = 1'b0;
    miss_rw_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (req_cmd)
          CACHE::READ, CACHE::WRITE: begin
            if (match_c) begin
              respcyc  = 1'b1;
              hit_rw_c = 1'b1;
              hit_wr_c = (req_cmd == CACHE::WRITE);
            end else begin
              latch_miss_c = 1'b1;
              miss_rw_c    = 1'b1;
              flush_d      = 1'b0;
              state_d      = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_FILL;
            end
          end
          CACHE::FLUSH: begin
            // a flush of an absent line completes at once; a clean hit is
            // invalidated now and reports on the following cycle
            respcyc = !match_c;
            if (match_c) begin
              if (dirty_q[req_idx]) begin
                latch_miss_c = 1'b1;
                flush_d      = 1'b1;
                state_d      = S_WB;
              end else begin
                inv_req_c = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      S_WB: begin
        wt_reqcyc = 1'b1;
        if (wt_respcyc) begin
          wb_done_c = 1'b1;
          state_d   = flush_q ? S_IDLE : S_FILL;
        end
      end
      S_FILL: begin
        rd_reqcyc = 1'b1;
        if (rd_respcyc) begin
          fill_en_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // valid and dirty bits per line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (hit_wr_c) dirty_q[req_idx] <= 1'b1;
      if (inv_req_c) valid_q[req_idx] <= 1'b0;
      if (wb_done_c) begin
        dirty_q[miss_idx] <= 1'b0;
        if (flush_q) valid_q[miss_idx] <= 1'b0;
      end
      if (fill_en_c) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // tag array, written only on a line fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_LINES); i++) tag_q[i] <= '0;
    end else if (fill_en_c) begin
      tag_q[miss_idx] <= miss_tag;
    end
  end

  // line data: whole-line fill or single-word write hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_LINES); i++) line_q[i] <= '0;
    end else begin
      if (fill_en_c) line_q[miss_idx] <= rd_data;
      if (hit_wr_c) line_q[req_idx][{req_word, 6'd0} +: 64] <= req_data;
    end
  end

`ifdef DM_WB_DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic        unused_bits;

  // event counters, free-running with natural wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_rw_c)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_rw_c) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_done_c) wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign wb_cnt      = wb_cnt_q;
  assign unused_bits = ^req_addr[2:0];
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[2:0], hit_rw_c, miss_rw_c};
`endif

endmodule

// File: tb/tb_dm_wb_dcache.sv
// tb_dm_wb_dcache: directed test-plan steps followed by random traffic,
// checked against a flat-memory reference model and a per-index tag model.
module tb_dm_wb_dcache;
  import CACHE::*;

  logic         clk;
  logic         reset;
  cache_cmd_t   req_cmd;
  logic [63:0]  req_addr;
  logic [63:0]  req_data;
  logic         respcyc;
  logic [63:0]  resp_data;
  logic         rd_reqcyc;
  logic [63:0]  rd_addr;
  logic         rd_respcyc;
  logic [511:0] rd_data;
  logic         wt_reqcyc;
  logic [63:0]  wt_addr;
  logic [511:0] wt_data;
  logic         wt_respcyc;
`ifdef DM_WB_DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  dm_wb_dcache #(.NUM_LINES(8), .ADDR_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .respcyc    (respcyc),
    .resp_data  (resp_data),
    .rd_reqcyc  (rd_reqcyc),
    .rd_addr    (rd_addr),
    .rd_respcyc (rd_respcyc),
    .rd_data    (rd_data),
    .wt_reqcyc  (wt_reqcyc),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .wt_respcyc (wt_respcyc)
`ifdef DM_WB_DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  int tests;
  int fails;

  // backing memory and the value the core should observe at each word
  logic [63:0] back [logic [63:0]];
  logic [63:0] arch [logic [63:0]];
  // what the cache should hold per index
  bit          mv [8];
  bit          md [8];
  logic [63:0] mt [8];

  // details of the last transaction, for directed checks
  logic [63:0]  last_rd_addr;
  logic [63:0]  last_wt_addr;
  logic [511:0] last_wt_data;
  int           last_nwt;
  int           last_nrd;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] back_rd(input logic [63:0] a);
    if (back.exists(a)) return back[a];
    return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0]};
  endfunction

  function automatic logic [63:0] arch_rd(input logic [63:0] a);
    if (arch.exists(a)) return arch[a];
    return back_rd(a);
  endfunction

  task automatic do_reset();
    req_cmd    = IDLE;
    rd_respcyc = 1'b0;
    wt_respcyc = 1'b0;
    reset      = 1'b0;
    #1;
    chk("rst_respcyc", 512'(respcyc), 512'(0));
    chk("rst_rd_req", 512'(rd_reqcyc), 512'(0));
    chk("rst_wt_req", 512'(wt_reqcyc), 512'(0));
    chk("rst_resp_data", 512'(resp_data), 512'(0));
    chk("rst_rd_addr", 512'(rd_addr), 512'(0));
    chk("rst_wt_addr", 512'(wt_addr), 512'(0));
    chk("rst_wt_data", wt_data, 512'(0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    arch.delete();
  endtask

  // one core request, serving the bus with dr/dw-cycle handshake delays
  task automatic do_req(input cache_cmd_t cmd, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata);
    int unsigned idx;
    logic [63:0] tg, line_a, ewa;
    logic [511:0] ewd, fill;
    bit hit, exp_resp, exp_wb, exp_rd, got, both;
    int exp_lat, lat, nrd, nwt, rdw, wtw, limit, dr, dw;
    idx    = int'(addr[8:6]);
    tg     = addr >> 9;
    line_a = {addr[63:6], 6'd0};
    hit    = mv[idx] && (mt[idx] == tg);
    dr     = int'($urandom_range(1, 3));
    dw     = int'($urandom_range(1, 3));
    ewa    = (mt[idx] << 9) | (64'(idx) << 6);
    exp_resp = 1'b1; exp_wb = 1'b0; exp_rd = 1'b0; exp_lat = 0;
    case (cmd)
      READ, WRITE: if (!hit) begin
        exp_wb  = mv[idx] && md[idx];
        exp_rd  = 1'b1;
        exp_lat = (exp_wb ? dw : 0) + dr + 1;
      end
      FLUSH: if (hit) begin
        exp_wb  = md[idx];
        exp_lat = md[idx] ? dw + 1 : 1;
      end
      default: exp_resp = 1'b0;
    endcase
    req_cmd = cmd; req_addr = addr; req_data = wdata;
    got = 0; both = 0; lat = 0; nrd = 0; nwt = 0; rdw = 0; wtw = 0; rdata = '0;
    limit = (cmd == IDLE) ? 3 : 60;
    for (int c = 0; c < limit && !got; c++) begin
      #1;
      if (rd_reqcyc && wt_reqcyc) both = 1;
      if (respcyc) begin
        got = 1; lat = c; rdata = resp_data;
      end else begin
        if (wt_reqcyc) begin
          wtw++;
          if (wtw == dw) begin
            nwt++;
            for (int w = 0; w < 8; w++) ewd[w*64 +: 64] = arch_rd(ewa + 64'(w*8));
            chk("wb_addr", 512'(wt_addr), 512'(ewa));
            chk("wb_data", wt_data, ewd);
            for (int w = 0; w < 8; w++) back[ewa + 64'(w*8)] = wt_data[w*64 +: 64];
            last_wt_addr = wt_addr; last_wt_data = wt_data;
            wt_respcyc = 1'b1;
          end
        end
        if (rd_reqcyc) begin
          rdw++;
          if (rdw == dr) begin
            nrd++;
            chk("fill_addr", 512'(rd_addr), 512'(line_a));
            for (int w = 0; w < 8; w++) fill[w*64 +: 64] = back_rd(line_a + 64'(w*8));
            rd_data = fill; last_rd_addr = rd_addr;
            rd_respcyc = 1'b1;
          end
        end
      end
      @(negedge clk);
      rd_respcyc = 1'b0;
      wt_respcyc = 1'b0;
    end
    req_cmd = IDLE;
    last_nwt = nwt; last_nrd = nrd;
    chk("respcyc_seen", 512'(got), 512'(exp_resp));
    chk("wb_count", 512'(nwt), 512'(exp_wb));
    chk("fill_count", 512'(nrd), 512'(exp_rd));
    chk("rd_wt_overlap", 512'(both), 512'(0));
    if (got) chk("latency", 512'(lat), 512'(exp_lat));
    if (got && cmd == READ) chk("read_data", 512'(rdata), 512'(arch_rd({addr[63:3], 3'd0})));
    if (got) begin
      case (cmd)
        READ, WRITE: begin
          if (!hit) begin mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0; end
          if (cmd == WRITE) begin arch[{addr[63:3], 3'd0}] = wdata; md[idx] = 1'b1; end
        end
        FLUSH: if (hit) begin mv[idx] = 1'b0; md[idx] = 1'b0; end
        default: ;
      endcase
    end else if (exp_resp) begin
      do_reset();
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] a;
    cache_cmd_t  cmd;
    int unsigned r;
    clk = 1'b0; tests = 0; fails = 0;
    req_addr = '0; req_data = '0; rd_data = '0;
    last_rd_addr = '0; last_wt_addr = '0; last_wt_data = '0;
    do_reset();

    // refill and hit on a neighbouring word
    back[64'h1010] = 64'hAA;
    do_req(READ, 64'h1000, 64'h0, rd);
    chk("tp_fill_addr", 512'(last_rd_addr), 512'(64'h1000));
    chk("tp_fill_nowb", 512'(last_nwt), 512'(0));
    do_req(READ, 64'h1010, 64'h0, rd);
    chk("tp_read_aa", 512'(rd), 512'(64'hAA));

    // write hit, read back
    do_req(WRITE, 64'h1008, 64'h55, rd);
    do_req(READ, 64'h1008, 64'h0, rd);
    chk("tp_read_55", 512'(rd), 512'(64'h55));

    // dirty victim eviction
    do_req(READ, 64'h1200, 64'h0, rd);
    chk("tp_evict_addr", 512'(last_wt_addr), 512'(64'h1000));
    chk("tp_evict_w1", 512'(last_wt_data[127:64]), 512'(64'h55));
    chk("tp_evict_fill", 512'(last_rd_addr), 512'(64'h1200));

    // clean victim: fill only
    do_req(READ, 64'h1400, 64'h0, rd);
    chk("tp_clean_nowb", 512'(last_nwt), 512'(0));

    // flush a dirty line, then it misses
    do_req(WRITE, 64'h1000, 64'h1234, rd);
    do_req(FLUSH, 64'h1000, 64'h0, rd);
    chk("tp_flush_wb", 512'(last_nwt), 512'(1));
    do_req(READ, 64'h1000, 64'h0, rd);
    chk("tp_flush_miss", 512'(last_nrd), 512'(1));
    chk("tp_flush_data", 512'(rd), 512'(64'h1234));

    // reset in the middle of a fill
    do_reset();
    req_cmd = READ; req_addr = 64'h1000;
    @(negedge clk); #1;
    chk("tp_fill_pending", 512'(rd_reqcyc), 512'(1));
    reset = 1'b0;
    #1;
    chk("tp_async_rd_drop", 512'(rd_reqcyc), 512'(0));
    chk("tp_async_wt_low", 512'(wt_reqcyc), 512'(0));
    req_cmd = IDLE;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    arch.delete();
    do_req(READ, 64'h1000, 64'h0, rd);
    chk("tp_post_rst_miss", 512'(last_nrd), 512'(1));

    // random traffic over four tags sharing the eight indices
    for (int n = 0; n < 250; n++) begin
      a = (64'(8 + $urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 7)) << 6)
        | (64'($urandom_range(0, 7)) << 3);
      r = $urandom_range(0, 19);
      cmd = (r < 9) ? READ : (r < 17) ? WRITE : (r < 19) ? FLUSH : IDLE;
      do_req(cmd, a, {$urandom, $urandom}, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
